acc_mem_arbiter: RTL
====================

// Module: acc_mem_arbiter
// PURPOSE
// - Responder end of the accelerator memory request protocol: serves NUM_ACC accelerator control units' read/write requests.
// - Round-robin arbitration onto the single accelerator port of Data Memory.
// - Returns per-requester read_data_valid / write_done pulses.
// - Sits between the accelerator array and Data Memory; the CPU port is outside this block.
// PARAMETERS
// - NUM_ACC         4    number of accelerator requesters (>=2)
// - ADDR_W          16   request/memory address width
// - RD_DATA_W       512  read data width (one full message block)
// - WR_DATA_W       32   write data width
// - MEM_RD_LATENCY  2    cycles from mem_rd_en to mem_rd_data valid (>=1)
// PORTS
// - clk           in   1                  clock
// - rst_n         in   1                  synchronous active-low reset
// - acc_rd_en     in   NUM_ACC            per-acc read request, held until its rd_valid
// - acc_rd_addr   in   NUM_ACC*ADDR_W     per-acc read address, slice i = [i*ADDR_W +: ADDR_W]
// - acc_wr_en     in   NUM_ACC            per-acc write request, held until its wr_done
// - acc_wr_addr   in   NUM_ACC*ADDR_W     per-acc write address
// - acc_wr_data   in   NUM_ACC*WR_DATA_W  per-acc write data
// - acc_rd_valid  out  NUM_ACC            one-hot, 1-cycle pulse: acc_rd_data belongs to acc i
// - acc_rd_data   out  RD_DATA_W          shared registered read data bus
// - acc_wr_done   out  NUM_ACC            one-hot, 1-cycle pulse: write of acc i committed
// - mem_rd_en     out  1                  Data Memory read strobe (1 cycle)
// - mem_wr_en     out  1                  Data Memory write strobe (1 cycle)
// - mem_addr      out  ADDR_W             Data Memory address
// - mem_wr_data   out  WR_DATA_W          Data Memory write data
// - mem_rd_data   in   RD_DATA_W          Data Memory read data, valid MEM_RD_LATENCY cycles after mem_rd_en
// - perf_grants   out  NUM_ACC*16         per-acc grant counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr pointer 0; any in-flight memory read is abandoned and its data never returned.
// - FSM IDLE -> ISSUE -> (RD_WAIT) -> RESP -> IDLE.
// - IDLE: requester i is pending if acc_rd_en[i] | acc_wr_en[i].
//   - Pick the first pending index at or after ptr, wrapping modulo NUM_ACC.
//   - Latch index, op, address and data; go to ISSUE. No pending: stay.
// - ISSUE: 1-cycle mem_wr_en or mem_rd_en with latched addr/data.
//   - Write goes to RESP; read goes to RD_WAIT.
//   - Both en of one acc high: write served first; read is served on a later grant.
// - RD_WAIT: counts MEM_RD_LATENCY cycles, then registers mem_rd_data into acc_rd_data and goes to RESP.
// - RESP: pulse acc_rd_valid[idx] or acc_wr_done[idx] for exactly 1 cycle.
//   - acc_rd_data holds its value until the next read response.
//   - Set ptr = (idx+1) mod NUM_ACC; go to IDLE.
// - Latency: write is 2 cycles from IDLE grant to wr_done; read is 2+MEM_RD_LATENCY cycles.
//   - Requests are sampled only in IDLE, so a requester dropping en after its pulse is never double-served.
// - Request dropped mid-transaction: the transaction still completes and pulses; the requester must ignore it.
// - At most one memory op in flight; no pipelining.
//   - mem_rd_en and mem_wr_en are never high together.
// CONFIGURATION
// - ACC_ARB_PERF_CNT_EN defined:
//   - perf_grants slice i counts completed transactions of acc i (16-bit, saturates at 16'hFFFF).
//   - Counters clear on reset.
// - Undefined: perf_grants tied to 0 and no counter flops are built.
// STRUCTURE
// - Package acc_arb_pkg: arb_state_t enum (IDLE, ISSUE, RD_WAIT, RESP), op_t enum (OP_RD, OP_WR), PERF_CNT_W=16.
// - Sub-module acc_rr_picker: combinational round-robin picker.
//   - Inputs: req[NUM_ACC], ptr.
//   - Outputs: grant_idx, any_req.
// - The FSM, latch registers and latency counter stay in acc_mem_arbiter.
// TESTING
// - T1 single write: acc1 wr addr=16'h5000 data=32'h5 -> mem_wr_en 1 cycle with 5000/5; acc_wr_done=4'b0010 2 cycles after grant.
// - T2 single read: acc0 rd addr=16'h1010, memory returns 512'hA5..A5 -> acc_rd_valid=4'b0001 at 2+MEM_RD_LATENCY; acc_rd_data=A5..A5.
// - T3 round-robin: all 4 acc request writes continuously -> wr_done order 0,1,2,3,0; ptr wraps from 3 to 0.
// - T4 rd+wr same acc: acc2 asserts both -> write done first; read serviced on next grant to acc2.
// - T5 reset mid-read: assert rst_n=0 in RD_WAIT -> no acc_rd_valid pulse; all outputs 0; first grant after reset goes to acc0.
// - T6 ACC_ARB_PERF_CNT_EN: 3 acc3 writes -> perf_grants[3*16+:16]=3, others 0; macro off -> perf_grants==0.

Source files
------------

// File: rtl/acc_arb_pkg.sv
// Shared types and constants for the accelerator memory arbiter.
package acc_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/acc_mem_arbiter_if.sv
// Accelerator request/response and Data Memory signals of the arbiter.
// master = requesters + memory side, slave = the arbiter.
interface acc_mem_arbiter_if
  import acc_arb_pkg::*;
#(
  parameter int NUM_ACC   = 4,
  parameter int ADDR_W    = 16,
  parameter int RD_DATA_W = 512,
  parameter int WR_DATA_W = 32
) ();
  logic [NUM_ACC-1:0]            acc_rd_en;
  logic [NUM_ACC*ADDR_W-1:0]     acc_rd_addr;
  logic [NUM_ACC-1:0]            acc_wr_en;
  logic [NUM_ACC*ADDR_W-1:0]     acc_wr_addr;
  logic [NUM_ACC*WR_DATA_W-1:0]  acc_wr_data;
  logic [NUM_ACC-1:0]            acc_rd_valid;
  logic [RD_DATA_W-1:0]          acc_rd_data;
  logic [NUM_ACC-1:0]            acc_wr_done;
  logic                          mem_rd_en;
  logic                          mem_wr_en;
  logic [ADDR_W-1:0]             mem_addr;
  logic [WR_DATA_W-1:0]          mem_wr_data;
  logic [RD_DATA_W-1:0]          mem_rd_data;
  logic [NUM_ACC*PERF_CNT_W-1:0] perf_grants;

  modport master (
    output acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data, mem_rd_data,
    input  acc_rd_valid, acc_rd_data, acc_wr_done,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, perf_grants
  );

  modport slave (
    input  acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data, mem_rd_data,
    output acc_rd_valid, acc_rd_data, acc_wr_done,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, perf_grants
  );
endinterface

// File: rtl/acc_rr_picker.sv
// Combinational round-robin picker: first pending requester at or after ptr,
// wrapping modulo NUM_ACC.
module acc_rr_picker #(
  parameter int NUM_ACC = 4,
  parameter int IDX_W   = $clog2(NUM_ACC)
) (
  input  logic [NUM_ACC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);
  int             j;
  logic [IDX_W-1:0] jj;
  logic           found;

  always_comb begin
    any_req   = |req;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_ACC) j = j - NUM_ACC;
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant_idx = jj;
      end
    end
  end
endmodule

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter of NUM_ACC accelerator read/write requesters onto the
// single accelerator port of Data Memory. Optional ACC_ARB_PERF_CNT_EN adds per-acc grant counters.
module acc_mem_arbiter
  import acc_arb_pkg::*;
#(
  parameter int NUM_ACC        = 4,
  parameter int ADDR_W         = 16,
  parameter int RD_DATA_W      = 512,
  parameter int WR_DATA_W      = 32,
  parameter int MEM_RD_LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  acc_mem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ACC);
  localparam int CNT_W = $clog2(MEM_RD_LATENCY + 1);

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    op_t                  op;
    logic [ADDR_W-1:0]    addr;
    logic [WR_DATA_W-1:0] data;
  } req_t;

  arb_state_t           state, state_nxt;
  req_t                 cur;
  logic [IDX_W-1:0]     ptr, grant_idx;
  logic                 any_req;
  logic [NUM_ACC-1:0]   req;
  logic [CNT_W-1:0]     lat_cnt;
  logic                 lat_done;
  logic [RD_DATA_W-1:0] rd_data_q;

  assign req      = bus.acc_rd_en | bus.acc_wr_en;
  assign lat_done = (lat_cnt == CNT_W'(MEM_RD_LATENCY - 1));

  acc_rr_picker #(.NUM_ACC(NUM_ACC), .IDX_W(IDX_W)) u_picker (
    .req       (req),
    .ptr       (ptr),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (cur.op == OP_WR) ? RESP : RD_WAIT;
      RD_WAIT: if (lat_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when one requester has both enables up; its read waits for a later grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= '0;
      ptr       <= '0;
      lat_cnt   <= '0;
      rd_data_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        cur.idx <= grant_idx;
        if (bus.acc_wr_en[grant_idx]) begin
          cur.op   <= OP_WR;
          cur.addr <= bus.acc_wr_addr[grant_idx*ADDR_W +: ADDR_W];
          cur.data <= bus.acc_wr_data[grant_idx*WR_DATA_W +: WR_DATA_W];
        end else begin
          cur.op   <= OP_RD;
          cur.addr <= bus.acc_rd_addr[grant_idx*ADDR_W +: ADDR_W];
          cur.data <= '0;
        end
      end
      lat_cnt <= (state == RD_WAIT) ? lat_cnt + 1'b1 : '0;
      if (state == RD_WAIT && lat_done) rd_data_q <= bus.mem_rd_data;
      if (state == RESP)
        ptr <= (cur.idx == IDX_W'(NUM_ACC - 1)) ? '0 : cur.idx + 1'b1;
    end
  end

  assign bus.acc_rd_data = rd_data_q;

  always_comb begin
    bus.mem_rd_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wr_data  = '0;
    bus.acc_rd_valid = '0;
    bus.acc_wr_done  = '0;
    case (state)
      ISSUE: begin
        bus.mem_addr = cur.addr;
        if (cur.op == OP_WR) begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_data = cur.data;
        end else begin
          bus.mem_rd_en = 1'b1;
        end
      end
      RESP: begin
        if (cur.op == OP_RD) bus.acc_rd_valid[cur.idx] = 1'b1;
        else                 bus.acc_wr_done[cur.idx]  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACC_ARB_PERF_CNT_EN
  for (genvar i = 0; i < NUM_ACC; i++) begin : g_perf
    logic [PERF_CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else if (state == RESP && cur.idx == IDX_W'(i) && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign bus.perf_grants[i*PERF_CNT_W +: PERF_CNT_W] = cnt;
  end
`else
  assign bus.perf_grants = '0;
`endif
endmodule
